fp_square_sp_seq: RTL and testbench

//  Sequential IEEE-754 single-precision squarer, y = x*x; the inverse operation of the sqrt datapath.

---
 rtl/fp_square_sp_seq_if.sv | 13 +
 rtl/fp_square_sp_seq.sv | 114 +++++++++++
 tb/tb_fp_square_sp_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_square_sp_seq_if.sv
// Handshake bundle for the sequential single-precision squarer:
// operand in with valid/ready, result out with valid/ready.
interface fp_square_sp_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (output in_valid, x, out_ready, input in_ready, out_valid, y);
  modport slave  (input in_valid, x, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/fp_square_sp_seq.sv
// Sequential IEEE-754 single-precision squarer, y = x*x, using an iterative
// shift-add mantissa multiply; one operation in flight, sign always cleared.
//
//  state | meaning
//  IDLE  | ready for an operand; special operands resolve straight to DONE
//  MUL   | accumulate MUL_BITS multiplier bits per cycle, N = 24/MUL_BITS cycles
//  NORM  | normalise, round half-up, range-check and pack y
//  DONE  | y valid and held until out_ready
module fp_square_sp_seq #(
  parameter int MUL_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_square_sp_seq_if.slave  bus
);

  localparam int N = 24 / MUL_BITS;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [7:0]  exp_r;
  logic [47:0] mcand;
  logic [47:0] acc;
  logic [23:0] mult;
  logic [31:0] y_r;

  logic        accept;
  logic [7:0]  x_exp;
  logic        x_special;
  logic [47:0] pp;

  logic        h;
  logic        rnd;
  logic [22:0] m_trunc;
  logic [23:0] m_rnd;
  logic        c;
  logic [22:0] m_fin;
  logic signed [9:0] e;
  logic [31:0] y_norm;

  assign accept    = bus.in_valid && (state == IDLE);
  assign x_exp     = bus.x[30:23];
  assign x_special = (x_exp == 8'd0) || (x_exp == 8'hFF);
  assign pp        = mcand * 48'(mult[MUL_BITS-1:0]);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y         = y_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = x_special ? DONE : MUL;
      MUL:  if (cnt == 5'(N - 1)) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product lies in [2^46, 2^48); h says which binade it landed in.
  always_comb begin
    h       = acc[47];
    m_trunc = h ? acc[46:24] : acc[45:23];
    rnd     = h ? acc[23]    : acc[22];
    m_rnd   = {1'b0, m_trunc} + {23'd0, rnd};
    c       = m_rnd[23];
    m_fin   = c ? 23'd0 : m_rnd[22:0];
    e       = $signed({1'b0, exp_r, 1'b0}) - 10'sd127
              + $signed({9'd0, h}) + $signed({9'd0, c});
    if (e >= 10'sd255)    y_norm = 32'h7F80_0000;
    else if (e <= 10'sd0) y_norm = 32'h0000_0000;
    else                  y_norm = {1'b0, e[7:0], m_fin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      exp_r <= '0;
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      y_r   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          exp_r <= x_exp;
          mcand <= {24'd0, 1'b1, bus.x[22:0]};
          mult  <= {1'b1, bus.x[22:0]};
          acc   <= '0;
          cnt   <= '0;
          if (x_exp == 8'd0)       y_r <= 32'h0000_0000;
          else if (x_exp == 8'hFF) y_r <= 32'h7F80_0000;
        end
        MUL: begin
          acc   <= acc + pp;
          mcand <= mcand << MUL_BITS;
          mult  <= mult >> MUL_BITS;
          cnt   <= cnt + 5'd1;
        end
        NORM: y_r <= y_norm;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square_sp_seq.sv
// Self-checking bench for fp_square_sp_seq (MUL_BITS=1): scoreboard of expected
// results, latency, output hold, ignored in_valid while busy, async abort.
module tb_fp_square_sp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_square_sp_seq_if bus ();

  fp_square_sp_seq #(.MUL_BITS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Reference: exact 48-bit product, half-up rounding by adding half an ulp then shifting.
  function automatic logic [31:0] model(input logic [31:0] xv);
    logic [63:0] mx, p, q;
    int sh, ex, ev;
    ev = int'(xv[30:23]);
    if (ev == 0)   return 32'h0000_0000;
    if (ev == 255) return 32'h7F80_0000;
    mx = {40'd0, 1'b1, xv[22:0]};
    p  = mx * mx;
    sh = p[47] ? 24 : 23;
    ex = 2 * ev - 127 + (p[47] ? 1 : 0);
    q  = (p + (64'd1 << (sh - 1))) >> sh;
    if (q[24]) begin
      ex = ex + 1;
      q  = q >> 1;
    end
    if (ex >= 255) return 32'h7F80_0000;
    if (ex <= 0)   return 32'h0000_0000;
    return {1'b0, ex[7:0], q[22:0]};
  endfunction

  task automatic issue(input logic [31:0] xv);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    bus.x        = xv;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(xv));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge to the edge that first sees out_valid.
  task automatic wait_out(input int lat0, output int lat, output bit ok);
    lat = lat0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    ok = (bus.out_valid === 1'b1);
  endtask

  task automatic do_op(input logic [31:0] xv, input int exp_lat, input string name);
    int lat;
    bit ok;
    logic [31:0] expv;
    bus.out_ready = 1'b1;
    issue(xv);
    wait_out(1, lat, ok);
    expv = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, lat);
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.y !== expv) begin
      errors++;
      $display("FAIL %s y: x=%h got %h required %h", name, xv, bus.y, expv);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.x         = 32'h0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 32'h0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%h required 1/0/00000000", bus.in_ready, bus.out_valid, bus.y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(32'h4000_0000, 26, "two");
    do_op(32'h3FC0_0000, 26, "one_half");
    do_op(32'hC040_0000, 26, "neg_three");
    do_op(32'h3F80_0001, 26, "one_ulp");
    do_op(32'h3F80_0000, 26, "one");
  endtask

  task automatic test_specials();
    do_op(32'h0000_0001, 1,  "denormal");
    do_op(32'h8000_0000, 1,  "neg_zero");
    do_op(32'h7FC0_0000, 1,  "nan");
    do_op(32'hFF80_0000, 1,  "neg_inf");
    do_op(32'h60AD_78EC, 26, "overflow");
    do_op(32'h1F80_0000, 26, "underflow");
  endtask

  task automatic test_random();
    logic [31:0] xv;
    for (int i = 0; i < 40; i++) begin
      xv = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      do_op(xv, 26, "random");
    end
  endtask

  task automatic test_hold();
    int lat;
    bit ok;
    logic [31:0] expv;
    bus.out_ready = 1'b0;
    issue(32'h3FC0_0000);
    wait_out(1, lat, ok);
    expv = exp_q.pop_front();
    checks++;
    if (!ok || bus.y !== expv) begin
      errors++;
      $display("FAIL hold first: out_valid=%b y=%h required 1/%h", bus.out_valid, bus.y, expv);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== expv || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: out_valid=%b y=%h in_ready=%b required 1/%h/0", i, bus.out_valid, bus.y, bus.in_ready, expv);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold release: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit ok;
    logic [31:0] expv;
    bus.out_ready = 1'b1;
    issue(32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      bus.x        = 32'h4100_0000 + 32'(i);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.x        = 32'h0;
    wait_out(6, lat, ok);
    expv = exp_q.pop_front();
    checks++;
    if (!ok || lat !== 26 || bus.y !== expv) begin
      errors++;
      $display("FAIL busy_ignore: out_valid=%b lat=%0d y=%h required 1/26/%h", bus.out_valid, lat, bus.y, expv);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_ignore after %0d: out_valid=%b in_ready=%b required 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b1;
    issue(32'h4000_0000);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== 32'h0) begin
      errors++;
      $display("FAIL abort: out_valid=%b in_ready=%b y=%h required 0/1/00000000", bus.out_valid, bus.in_ready, bus.y);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort stale result at %0d: out_valid=%b required 0", i, bus.out_valid);
      end
    end
    do_op(32'h4040_0000, 26, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_specials();
    test_random();
    test_hold();
    test_busy_ignore();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
